// File: rtl/multiport_regfile_pkg.sv
// rtl/multiport_regfile_pkg.sv - shared decode/issue constants for the multi-port register file
package multiport_regfile_pkg;

  localparam int DEF_REG_NUM_BITWIDTH = 5;
  localparam int DEF_WORD_BITWIDTH    = 32;
  localparam int DEF_READ_PORTS       = 2;
  localparam int DEF_WRITE_PORTS      = 2;
  localparam int DEF_PEND_BITS        = 2;

  localparam int NUM_REGS = 2 ** DEF_REG_NUM_BITWIDTH;
  localparam int ZERO_REG = 0;
  localparam int PEND_MAX = 2 ** DEF_PEND_BITS - 1;

endpackage

// File: rtl/multiport_regfile_scoreboard.sv
// rtl/multiport_regfile_scoreboard.sv - per-register pending-write counters, issue_ready, read_busy, sb_error
// REGFILE_BYPASS_EN: a same-cycle write that retires the last pending entry hides read_busy.
module regfile_scoreboard
  import multiport_regfile_pkg::*;
#(
  parameter int REG_NUM_BITWIDTH = DEF_REG_NUM_BITWIDTH,
  parameter int READ_PORTS       = DEF_READ_PORTS,
  parameter int WRITE_PORTS      = DEF_WRITE_PORTS,
  parameter int PEND_BITS        = DEF_PEND_BITS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [READ_PORTS*REG_NUM_BITWIDTH-1:0]  regToRead,
  input  logic [WRITE_PORTS-1:0]                 doRegWrite,
  input  logic [WRITE_PORTS*REG_NUM_BITWIDTH-1:0] regToWrite,
  input  logic                                  issue_en,
  input  logic [REG_NUM_BITWIDTH-1:0]            issue_reg,
  output logic                                  issue_ready,
  output logic [READ_PORTS-1:0]                  read_busy,
  output logic                                  sb_error
);

  localparam int RNB   = REG_NUM_BITWIDTH;
  localparam int NREGS = 2 ** RNB;
  localparam logic [RNB-1:0]       ZERO_IDX = RNB'(ZERO_REG);
  localparam logic [PEND_BITS-1:0] CNT_MAX  = '1;
  localparam logic [PEND_BITS-1:0] CNT_ONE  = PEND_BITS'(1);

  logic [PEND_BITS-1:0] cnt [NREGS];
  logic [NREGS-1:0]     write_hit;
  logic [NREGS-1:0]     issue_hit;
  logic                 collision;
  logic                 underflow;

  assign issue_ready = (issue_reg == ZERO_IDX) || (cnt[issue_reg] != CNT_MAX);

  // Collapse all write ports into one hit per register; a repeat hit is a collision.
  always_comb begin
    write_hit = '0;
    collision = 1'b0;
    for (int w = 0; w < WRITE_PORTS; w++) begin
      if (doRegWrite[w] && regToWrite[w*RNB +: RNB] != ZERO_IDX) begin
        if (write_hit[regToWrite[w*RNB +: RNB]]) collision = 1'b1;
        write_hit[regToWrite[w*RNB +: RNB]] = 1'b1;
      end
    end
  end

  always_comb begin
    issue_hit = '0;
    if (issue_en && issue_ready && issue_reg != ZERO_IDX) issue_hit[issue_reg] = 1'b1;
  end

  always_comb begin
    underflow = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (write_hit[r] && !issue_hit[r] && cnt[r] == '0) underflow = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      sb_error <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (issue_hit[r] && !write_hit[r])
          cnt[r] <= cnt[r] + CNT_ONE;
        else if (write_hit[r] && !issue_hit[r] && cnt[r] != '0)
          cnt[r] <= cnt[r] - CNT_ONE;
      end
      if (underflow || collision) sb_error <= 1'b1;
    end
  end

  always_comb begin
    read_busy = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      read_busy[p] = (cnt[regToRead[p*RNB +: RNB]] != '0);
`ifdef REGFILE_BYPASS_EN
      if (write_hit[regToRead[p*RNB +: RNB]] && cnt[regToRead[p*RNB +: RNB]] == CNT_ONE)
        read_busy[p] = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/multiport_regfile.sv
// rtl/multiport_regfile.sv - multi-port integer register file with write-pending scoreboard
// REGFILE_BYPASS_EN: forward same-cycle write data to read_data.
module multiport_regfile
  import multiport_regfile_pkg::*;
#(
  parameter int REG_NUM_BITWIDTH = DEF_REG_NUM_BITWIDTH,
  parameter int WORD_BITWIDTH    = DEF_WORD_BITWIDTH,
  parameter int READ_PORTS       = DEF_READ_PORTS,
  parameter int WRITE_PORTS      = DEF_WRITE_PORTS,
  parameter int PEND_BITS        = DEF_PEND_BITS
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [READ_PORTS*REG_NUM_BITWIDTH-1:0]  regToRead,
  output logic [READ_PORTS*WORD_BITWIDTH-1:0]     read_data,
  output logic [READ_PORTS-1:0]                   read_busy,
  input  logic [WRITE_PORTS-1:0]                  doRegWrite,
  input  logic [WRITE_PORTS*REG_NUM_BITWIDTH-1:0] regToWrite,
  input  logic [WRITE_PORTS*WORD_BITWIDTH-1:0]    write_data,
  input  logic                                    issue_en,
  input  logic [REG_NUM_BITWIDTH-1:0]             issue_reg,
  output logic                                    issue_ready,
  output logic                                    sb_error
);

  localparam int RNB   = REG_NUM_BITWIDTH;
  localparam int W     = WORD_BITWIDTH;
  localparam int NREGS = 2 ** RNB;
  localparam logic [RNB-1:0] ZERO_IDX = RNB'(ZERO_REG);

  logic [W-1:0] mem [NREGS];

  // Ports are visited in ascending order so the highest enabled port wins a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (doRegWrite[w] && regToWrite[w*RNB +: RNB] != ZERO_IDX)
          mem[regToWrite[w*RNB +: RNB]] <= write_data[w*W +: W];
      end
    end
  end

  always_comb begin
    read_data = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (regToRead[p*RNB +: RNB] != ZERO_IDX)
        read_data[p*W +: W] = mem[regToRead[p*RNB +: RNB]];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (doRegWrite[w] && regToRead[p*RNB +: RNB] != ZERO_IDX &&
            regToWrite[w*RNB +: RNB] == regToRead[p*RNB +: RNB])
          read_data[p*W +: W] = write_data[w*W +: W];
      end
`endif
    end
  end

  regfile_scoreboard #(
    .REG_NUM_BITWIDTH(REG_NUM_BITWIDTH),
    .READ_PORTS      (READ_PORTS),
    .WRITE_PORTS     (WRITE_PORTS),
    .PEND_BITS       (PEND_BITS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .regToRead  (regToRead),
    .doRegWrite (doRegWrite),
    .regToWrite (regToWrite),
    .issue_en   (issue_en),
    .issue_reg  (issue_reg),
    .issue_ready(issue_ready),
    .read_busy  (read_busy),
    .sb_error   (sb_error)
  );

endmodule

// File: tb/tb_multiport_regfile.sv
// tb/tb_multiport_regfile.sv - self-checking bench for multiport_regfile (default 5/32/2/2/2 build)
module tb_multiport_regfile;

  localparam int RP   = 2;
  localparam int WP   = 2;
  localparam int PMAX = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [9:0]  regToRead;
  logic [63:0] read_data;
  logic [1:0]  read_busy;
  logic [1:0]  doRegWrite;
  logic [9:0]  regToWrite;
  logic [63:0] write_data;
  logic        issue_en;
  logic [4:0]  issue_reg;
  logic        issue_ready;
  logic        sb_error;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  logic [31:0] m_mem [32];
  int          m_cnt [32];
  bit          m_wrote [32];
  bit          m_err;
  bit          m_issued;

  multiport_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .regToRead  (regToRead),
    .read_data  (read_data),
    .read_busy  (read_busy),
    .doRegWrite (doRegWrite),
    .regToWrite (regToWrite),
    .write_data (write_data),
    .issue_en   (issue_en),
    .issue_reg  (issue_reg),
    .issue_ready(issue_ready),
    .sb_error   (sb_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each register's pending count is (issues) - (cycles written), floored at 0.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[r] = 32'h0;
        m_cnt[r] = 0;
      end
      m_err = 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) m_wrote[r] = 1'b0;
      m_issued = issue_en && issue_reg != 5'd0 && m_cnt[issue_reg] < PMAX;
      for (int w = 0; w < WP; w++) begin
        if (doRegWrite[w] && regToWrite[w*5 +: 5] != 5'd0) begin
          if (m_wrote[regToWrite[w*5 +: 5]]) m_err = 1'b1;
          m_wrote[regToWrite[w*5 +: 5]] = 1'b1;
          m_mem[regToWrite[w*5 +: 5]]   = write_data[w*32 +: 32];
        end
      end
      for (int r = 1; r < 32; r++) begin
        if (m_issued && int'(issue_reg) == r) m_cnt[r] = m_cnt[r] + 1;
        if (m_wrote[r]) begin
          if (m_cnt[r] == 0) m_err = 1'b1;
          else m_cnt[r] = m_cnt[r] - 1;
        end
      end
    end
  end

  function automatic bit write_matches(int idx);
    bit hit = 1'b0;
    for (int w = 0; w < WP; w++)
      if (doRegWrite[w] && idx != 0 && int'(regToWrite[w*5 +: 5]) == idx) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [31:0] exp_rd(int p);
    int idx;
    logic [31:0] v;
    idx = int'(regToRead[p*5 +: 5]);
    v = (idx == 0) ? 32'h0 : m_mem[idx];
    if (BYP)
      for (int w = 0; w < WP; w++)
        if (doRegWrite[w] && idx != 0 && int'(regToWrite[w*5 +: 5]) == idx) v = write_data[w*32 +: 32];
    return v;
  endfunction

  function automatic logic exp_busy(int p);
    int idx;
    idx = int'(regToRead[p*5 +: 5]);
    if (BYP && m_cnt[idx] == 1 && write_matches(idx)) return 1'b0;
    return m_cnt[idx] != 0;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      for (int p = 0; p < RP; p++) begin
        chk($sformatf("model_rd%0d", p), {32'h0, read_data[p*32 +: 32]}, {32'h0, exp_rd(p)});
        chk($sformatf("model_busy%0d", p), {63'h0, read_busy[p]}, {63'h0, exp_busy(p)});
      end
      chk("model_ready", {63'h0, issue_ready}, {63'h0, (m_cnt[issue_reg] < PMAX)});
      chk("model_err", {63'h0, sb_error}, {63'h0, m_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    doRegWrite = '0;
    regToWrite = '0;
    write_data = '0;
    issue_en   = 1'b0;
    issue_reg  = '0;
  endtask

  task automatic set_rd(input int a, input int b);
    regToRead = {5'(b), 5'(a)};
  endtask

  task automatic set_wr(input int port, input int idx, input logic [31:0] d);
    doRegWrite[port]           = 1'b1;
    regToWrite[port*5 +: 5]    = 5'(idx);
    write_data[port*32 +: 32]  = d;
  endtask

  task automatic do_issue(input int idx);
    issue_en  = 1'b1;
    issue_reg = 5'(idx);
  endtask

  initial begin
    rst = 1'b1;
    regToRead = '0;
    clr();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_en = 1'b1;

    for (int r = 0; r < 32; r++) begin
      set_rd(r, r);
      issue_reg = 5'(r);
      #1;
      chk("reset_rd", read_data, 64'h0);
      chk("reset_busy", {62'h0, read_busy}, 64'h0);
      chk("reset_ready", {63'h0, issue_ready}, 64'h1);
      chk("reset_err", {63'h0, sb_error}, 64'h0);
      tick();
    end
    clr();

    // x5: issue, then write while reading it
    do_issue(5);
    tick();
    clr();
    set_rd(5, 5);
    set_wr(0, 5, 32'hDEADBEEF);
    #1;
    chk("x5_same_cycle", {32'h0, read_data[31:0]}, BYP ? 64'hDEADBEEF : 64'h0);
    chk("x5_busy_same", {63'h0, read_busy[0]}, BYP ? 64'h0 : 64'h1);
    tick();
    clr();
    #1;
    chk("x5_next_cycle", {32'h0, read_data[31:0]}, 64'hDEADBEEF);
    chk("x5_busy_next", {62'h0, read_busy}, 64'h0);

    // x7: two pending, then both ports write it in one cycle
    do_issue(7);
    tick();
    tick();
    clr();
    set_wr(0, 7, 32'h11);
    set_wr(1, 7, 32'h22);
    tick();
    clr();
    set_rd(7, 7);
    #1;
    chk("x7_winner", {32'h0, read_data[63:32]}, 64'h22);
    chk("x7_err", {63'h0, sb_error}, 64'h1);
    chk("x7_busy", {62'h0, read_busy}, 64'h3);
    set_wr(0, 7, 32'h33);
    tick();
    clr();
    tick();
    chk("x7_err_sticky", {63'h0, sb_error}, 64'h1);

    // x3: saturate at three, fourth issue is dropped
    for (int i = 0; i < 3; i++) begin
      do_issue(3);
      tick();
    end
    set_rd(3, 3);
    do_issue(3);
    #1;
    chk("x3_busy_sat", {62'h0, read_busy}, 64'h3);
    chk("x3_ready_sat", {63'h0, issue_ready}, 64'h0);
    tick();
    clr();
    for (int i = 0; i < 3; i++) begin
      set_wr(i % 2, 3, 32'(100 + i));
      tick();
      clr();
    end
    issue_reg = 5'd3;
    #1;
    chk("x3_busy_drained", {62'h0, read_busy}, 64'h0);
    chk("x3_ready_drained", {63'h0, issue_ready}, 64'h1);
    chk("x3_data", {32'h0, read_data[31:0]}, 64'h66);

    // x9: issue and write together keep count at one; x0 writes are dropped
    do_issue(9);
    tick();
    do_issue(9);
    set_wr(1, 9, 32'h99);
    tick();
    clr();
    set_rd(9, 9);
    #1;
    chk("x9_busy_held", {62'h0, read_busy}, 64'h3);
    set_rd(0, 9);
    set_wr(0, 0, 32'hFFFF);
    tick();
    clr();
    #1;
    chk("x0_read", {32'h0, read_data[31:0]}, 64'h0);
    chk("x0_busy", {62'h0, read_busy}, 64'h2);
    chk("x0_err_unchanged", {63'h0, sb_error}, 64'h1);

    // asynchronous reset clears sticky error without a clock edge
    rst = 1'b1;
    #1;
    chk("rst_async_err", {63'h0, sb_error}, 64'h0);
    chk("rst_async_busy", {62'h0, read_busy}, 64'h0);
    tick();
    rst = 1'b0;

    // x4 written with nothing pending: underflow
    set_wr(0, 4, 32'h1234);
    tick();
    clr();
    set_rd(4, 4);
    #1;
    chk("x4_data", read_data, 64'h0000123400001234);
    chk("x4_underflow", {63'h0, sb_error}, 64'h1);

    // reset mid-sequence with x3 pending
    do_issue(3);
    tick();
    clr();
    set_rd(4, 3);
    #1;
    chk("x3_pending", {62'h0, read_busy}, 64'h2);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {62'h0, read_busy}, 64'h0);
    chk("midrst_err", {63'h0, sb_error}, 64'h0);
    chk("midrst_rd", read_data, 64'h0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiport_regfile.md
# multiport_regfile

Parametrised multi-port integer register file with an integrated write-pending scoreboard, replacing the two-read/one-write register file in the decode stage of the RISC-V pipeline. It serves READ_PORTS combinational reads and WRITE_PORTS synchronous writebacks per cycle, with optional same-cycle write-to-read forwarding. It also tracks outstanding writes per register so that issue logic can detect RAW hazards and refuse over-subscribed destinations.

## Interface
- REG_NUM_BITWIDTH, 5: register index width; NUM_REGS = 2**REG_NUM_BITWIDTH
- WORD_BITWIDTH, 32: data word width
- READ_PORTS, 2: number of read ports (1..4)
- WRITE_PORTS, 2: number of writeback ports (1..2)
- PEND_BITS, 2: width of each per-register pending counter
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- regToRead  in  READ_PORTS*REG_NUM_BITWIDTH  read indices, port p at bits [p*RNB +: RNB]
- read_data  out  READ_PORTS*WORD_BITWIDTH  read data, combinational
- read_busy  out  READ_PORTS  the addressed register has a nonzero pending count
- doRegWrite  in  WRITE_PORTS  per-port write enable
- regToWrite  in  WRITE_PORTS*REG_NUM_BITWIDTH  write indices
- write_data  in  WRITE_PORTS*WORD_BITWIDTH  write data
- issue_en  in  1  an instruction with a destination issues this cycle
- issue_reg  in  REG_NUM_BITWIDTH  that instruction's destination register
- issue_ready  out  1  the pending counter of issue_reg is below its maximum
- sb_error  out  1  sticky error flag: underflow or write collision

## Operation
- Register 0 is hardwired to zero. Reads return 0. Writes, issues and pending counts for index 0 are ignored, and read_busy is 0 for it.
- Write: when doRegWrite[w] is set and the index is nonzero, the register takes write_data[w] at posedge. If several ports target the same register, the highest port index wins and sb_error is set.
- Read, without forwarding: read_data[p] returns the stored value.
- Pending counter per register, PEND_BITS wide, saturating at 2**PEND_BITS-1:
  - issue_en with issue_ready increments it.
  - issue_en with issue_ready low is ignored; the caller stalls.
  - Each enabled write decrements it. Same-register writes in one cycle decrement it once.
  - Issue and write to the same register in the same cycle leave it unchanged.
  - A write to a register whose count is 0 still updates data, leaves the count at 0 and sets sb_error (scoreboard underflow).
- issue_ready is combinational from issue_reg and the current counts. It does not account for writes in the same cycle.
- read_busy[p] is true when the count of regToRead[p] is nonzero.

## Timing
- Reset, asynchronous:
  - All registers, all pending counts and sb_error go to 0.
  - read_data is therefore 0 and read_busy 0 on every port; issue_ready is 1.
  - A reset mid-operation discards in-flight pending state. Issued instructions must be flushed by the pipeline in the same reset.
- Write latency: without forwarding, data is visible on read_data one cycle after the write edge; with forwarding, it is visible in the same cycle.
- Scoreboard latency: an issue at edge N makes read_busy visible in cycle N+1, and a write at edge N clears it for cycle N+1.
- sb_error is set on the edge that sees the fault and is held until rst.

## Configuration
- REGFILE_BYPASS_EN defined:
  - read_data[p] returns write_data of the highest-index enabled write port whose index equals regToRead[p] (nonzero) in the same cycle.
  - read_busy[p] is suppressed when such a matching write exists and the count equals 1.
- REGFILE_BYPASS_EN undefined: no combinational path from write ports to read_data or read_busy. The writer must wait one cycle.

## Structure
- The shared pipeline package holds the constants used by this block and the decode/issue logic:
  - NUM_REGS
  - the zero-register index
  - the default widths
  - a PEND_MAX constant
- One sub-module, regfile_scoreboard, holds the pending counters, issue_ready, read_busy and sb_error. The top module holds the storage array, write arbitration and read/forward muxing.

## Test plan
- Reset, then read all 32 registers on both ports → read_data 0, read_busy 0, issue_ready 1, sb_error 0.
- Write x5=0xDEADBEEF on port 0 while reading x5 → 0 that cycle without bypass (0xDEADBEEF with REGFILE_BYPASS_EN); 0xDEADBEEF the next cycle either way.
- Ports 0 and 1 both write x7 (0x11, 0x22) in one cycle → x7 reads 0x22 next cycle; sb_error goes 1 and stays 1.
- Issue x3 three times (PEND_BITS=2) → read_busy for x3 is 1 and issue_ready for x3 is 0. A fourth issue is ignored. Three writes to x3 → count returns to 0 and read_busy drops.
- Issue x9 and write x9 in the same cycle with count 1 → count stays 1 and read_busy stays 1. Then write x0=0xFFFF → x0 still reads 0 and there is no sb_error change.
- Write x4 with count 0 → data updated and sb_error set. Assert rst mid-sequence with x3 pending → every count is 0 and sb_error is 0 immediately, before the next clk edge.
